// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer controller.
package bcd_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic ss;
    logic load;
    logic clr;
  } btn_t;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-tick prescaler: wraps every TICK_DIV cycles while run is high, held at 0 by zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (zero)     cnt_d = '0;
    else if (run) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a 2-digit BCD up/down counter.
// Build option AUTO_RELOAD_EN: terminal tick reloads/clears the counter and keeps running.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ALARM_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               load_btn,
  input  logic               clear_btn,
  input  logic               mode_up,
  input  logic [DIGIT_W-1:0] preset1,
  input  logic [DIGIT_W-1:0] preset0,
  input  logic [DIGIT_W-1:0] q1,
  input  logic [DIGIT_W-1:0] q0,
  output logic               cnt_enable,
  output logic               cnt_up,
  output logic               cnt_load,
  output logic               cnt_clear,
  output logic [DIGIT_W-1:0] cnt_d1,
  output logic [DIGIT_W-1:0] cnt_d0,
  output logic               running,
  output logic               done,
  output logic               alarm
);

  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

  state_e             state_q;
  btn_t               btn_now, btn_prev_q, btn_edge_q;
  logic               cnt_enable_q, cnt_up_q, cnt_load_q, cnt_clear_q;
  logic [DIGIT_W-1:0] cnt_d1_q, cnt_d0_q;
  logic               running_q, done_q, alarm_q;
  logic [AW-1:0]      alarm_cnt_q;
  logic               tick, presc_run, presc_zero;
  logic               at_zero, at_preset, terminal;

  assign btn_now = '{ss: start_stop, load: load_btn, clr: clear_btn};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_prev_q <= '0;
      btn_edge_q <= '0;
    end else begin
      btn_prev_q <= btn_now;
      btn_edge_q <= btn_now & ~btn_prev_q;
    end
  end

  // Prescaler rests at 0 whenever stopped, so every entry into RUN starts a full period.
  assign presc_run  = (state_q == ST_RUN) || ((state_q == ST_DONE) && alarm_q);
  assign presc_zero = (state_q == ST_IDLE) || (state_q == ST_LOADED) || (state_q == ST_PAUSE);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clock (clock),
    .reset (reset),
    .run   (presc_run),
    .zero  (presc_zero),
    .tick  (tick)
  );

  assign at_zero   = ({q1, q0} == {BCD_ZERO, BCD_ZERO});
  assign at_preset = ({q1, q0} == {cnt_d1_q, cnt_d0_q});
  assign terminal  = cnt_up_q ? at_preset : at_zero;

  // All outputs registered: cnt_enable lands one cycle after the tick cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_enable_q <= 1'b0;
      cnt_up_q     <= 1'b0;
      cnt_load_q   <= 1'b0;
      cnt_clear_q  <= 1'b0;
      cnt_d1_q     <= '0;
      cnt_d0_q     <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_cnt_q  <= '0;
    end else begin
      cnt_enable_q <= 1'b0;
      cnt_load_q   <= 1'b0;
      cnt_clear_q  <= 1'b0;
      cnt_d1_q     <= bcd_clamp(preset1);
      cnt_d0_q     <= bcd_clamp(preset0);
      if (state_q != ST_RUN) cnt_up_q <= mode_up;
`ifdef AUTO_RELOAD_EN
      done_q <= 1'b0;
`endif

      if (alarm_q && tick) begin
        if (alarm_cnt_q == ALARM_LAST) alarm_q <= 1'b0;
        else                           alarm_cnt_q <= alarm_cnt_q + 1'b1;
      end

      if (btn_edge_q.clr) begin
        cnt_clear_q <= 1'b1;
        state_q     <= ST_IDLE;
        running_q   <= 1'b0;
        done_q      <= 1'b0;
        alarm_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_LOADED: begin
            if (btn_edge_q.load) begin
              cnt_load_q <= 1'b1;
              state_q    <= ST_LOADED;
            end else if (btn_edge_q.ss) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (btn_edge_q.load) begin
              cnt_load_q <= 1'b1;
            end else if (btn_edge_q.ss) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (btn_edge_q.ss) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (tick) begin
              if (!terminal) begin
                cnt_enable_q <= 1'b1;
              end else begin
`ifdef AUTO_RELOAD_EN
                if (cnt_up_q) cnt_clear_q <= 1'b1;
                else          cnt_load_q  <= 1'b1;
`else
                state_q   <= ST_DONE;
                running_q <= 1'b0;
`endif
                done_q      <= 1'b1;
                alarm_q     <= 1'b1;
                alarm_cnt_q <= '0;
              end
            end
          end
          ST_DONE: begin
            if (btn_edge_q.load || btn_edge_q.ss) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
              alarm_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_up     = cnt_up_q;
  assign cnt_load   = cnt_load_q;
  assign cnt_clear  = cnt_clear_q;
  assign cnt_d1     = cnt_d1_q;
  assign cnt_d0     = cnt_d0_q;
  assign running    = running_q;
  assign done       = done_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: preset table, directed sequences, then random stimulus vs a reference model.
module tb_bcd_timer_ctrl;

  localparam int TD = 4;
  localparam int AC = 2;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1;
  logic start_stop = 1'b0, load_btn = 1'b0, clear_btn = 1'b0, mode_up = 1'b0;
  logic [3:0] preset1 = 4'd0, preset0 = 4'd0;
  logic [3:0] q1, q0, cnt_d1, cnt_d0;
  logic cnt_enable, cnt_up, cnt_load, cnt_clear, running, done, alarm;
  logic [14:0] dut_v;

  int ntests = 0, nfail = 0;
  int cyc = 0, c_en = 0, c_ld = 0, c_cl = 0;
  int cval;

  bcd_timer_ctrl #(.TICK_DIV(TD), .ALARM_CYCLES(AC)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .load_btn(load_btn),
    .clear_btn(clear_btn), .mode_up(mode_up), .preset1(preset1), .preset0(preset0),
    .q1(q1), .q0(q0), .cnt_enable(cnt_enable), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .cnt_clear(cnt_clear), .cnt_d1(cnt_d1), .cnt_d0(cnt_d0), .running(running),
    .done(done), .alarm(alarm)
  );

  always #5 clock = ~clock;

  assign dut_v = {cnt_enable, cnt_up, cnt_load, cnt_clear, cnt_d1, cnt_d0, running, done, alarm};

  // Behavioural 2-digit BCD counter the controller drives.
  assign q1 = 4'(cval / 10);
  assign q0 = 4'(cval % 10);
  always @(posedge clock or posedge reset) begin
    if (reset)           cval <= 0;
    else if (cnt_clear)  cval <= 0;
    else if (cnt_load)   cval <= int'(cnt_d1) * 10 + int'(cnt_d0);
    else if (cnt_enable) cval <= cnt_up ? (cval + 1) % 100 : (cval + 99) % 100;
  end

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    c_en += int'(cnt_enable);
    c_ld += int'(cnt_load);
    c_cl += int'(cnt_clear);
  endtask

  // Hold a button for 3 cycles, then release it.
  task automatic press(input int b);
    case (b)
      0: start_stop = 1'b1;
      1: load_btn   = 1'b1;
      default: clear_btn = 1'b1;
    endcase
    step(); step(); step();
    start_stop = 1'b0; load_btn = 1'b0; clear_btn = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [2:0] m_prev, m_edge;   // {ss, load, clr}
  bit m_running, m_paused, m_finished;
  bit m_en, m_ld, m_cl, m_dn, m_up;
  int m_phase, m_val, m_alarm_left, m_d1, m_d0;

  task automatic model_reset();
    m_prev = '0; m_edge = '0;
    m_running = 0; m_paused = 0; m_finished = 0;
    m_en = 0; m_ld = 0; m_cl = 0; m_dn = 0; m_up = 0;
    m_phase = 0; m_val = 0; m_alarm_left = 0; m_d1 = 0; m_d0 = 0;
  endtask

  task automatic model_edge();
    logic [2:0] cur = {start_stop, load_btn, clear_btn};
    int  old_val = m_val;
    int  tgt     = m_d1 * 10 + m_d0;
    bit  was_run = m_running;
    bit  stopped = !m_running && !m_finished;
    bit  active  = m_running || (m_finished && m_alarm_left > 0);
    bit  tick    = active && (m_phase % TD == TD - 1);
    bit  term    = m_up ? (old_val == tgt) : (old_val == 0);
    if (m_cl)      m_val = 0;
    else if (m_ld) m_val = tgt;
    else if (m_en) m_val = m_up ? (m_val + 1) % 100 : (m_val + 99) % 100;
    m_en = 0; m_ld = 0; m_cl = 0;
    if (AUTO) m_dn = 0;
    if (m_alarm_left > 0 && tick) m_alarm_left--;
    if (m_edge[0]) begin
      m_cl = 1; m_running = 0; m_paused = 0; m_finished = 0; m_alarm_left = 0; m_dn = 0;
    end else if (m_finished) begin
      if (m_edge[1] || m_edge[2]) begin m_finished = 0; m_alarm_left = 0; end
    end else if (m_running) begin
      if (m_edge[2]) begin m_running = 0; m_paused = 1; end
      else if (tick) begin
        if (!term) m_en = 1;
        else begin
          m_alarm_left = AC;
          m_dn = 1;
          if (AUTO) begin if (m_up) m_cl = 1; else m_ld = 1; end
          else begin m_running = 0; m_finished = 1; end
        end
      end
    end else begin
      if (m_edge[1])      m_ld = 1;
      else if (m_edge[2]) begin m_running = 1; m_paused = 0; end
    end
    if (stopped)     m_phase = 0;
    else if (active) m_phase++;
    if (!was_run) m_up = mode_up;
    m_d1 = (preset1 > 9) ? 9 : int'(preset1);
    m_d0 = (preset0 > 9) ? 9 : int'(preset0);
    m_edge = cur & ~m_prev;
    m_prev = cur;
  endtask

  // ---------------- preset sanitising table ----------------
  typedef struct { logic [3:0] p1, p0, e1, e0; } vec_t;
  vec_t tbl[6];

  initial begin
    int n, last, r, k;
    bit all_run;
    logic [14:0] exp_v;

    tbl[0] = '{4'hF, 4'hA, 4'd9, 4'd9};
    tbl[1] = '{4'd1, 4'd2, 4'd1, 4'd2};
    tbl[2] = '{4'd9, 4'd9, 4'd9, 4'd9};
    tbl[3] = '{4'd0, 4'd0, 4'd0, 4'd0};
    tbl[4] = '{4'hA, 4'd3, 4'd9, 4'd3};
    tbl[5] = '{4'd5, 4'hC, 4'd5, 4'd9};

    step(); step();
    chk("reset_state", int'(dut_v), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      preset1 = tbl[i].p1; preset0 = tbl[i].p0;
      step();
      chk("sanitise", int'({cnt_d1, cnt_d0}), int'({tbl[i].e1, tbl[i].e0}));
    end

`ifndef AUTO_RELOAD_EN
    // Down count from 03
    mode_up = 1'b0; preset1 = 4'd0; preset0 = 4'd3;
    step(); step();
    c_ld = 0;
    press(1); step(); step(); step();
    chk("down_load_once", c_ld, 1);
    chk("down_loaded_val", cval, 3);
    c_en = 0; last = -1; n = 0;
    press(0);
    while (!done && n < 80) begin
      step(); n++;
      if (cnt_enable) begin
        if (last >= 0) chk("down_en_spacing", cyc - last, TD);
        last = cyc;
      end
    end
    chk("down_enables", c_en, 3);
    chk("down_done", int'(done), 1);
    chk("down_q_zero", cval, 0);
    chk("down_alarm_entry", int'(alarm), 1);
    chk("down_not_running", int'(running), 0);
    k = 1; n = 0;
    while (alarm && n < 40) begin step(); n++; if (alarm) k++; end
    chk("down_alarm_len", k, AC * TD);
    step(); step(); step(); step(); step();
    chk("down_done_latched", int'(done), 1);
    chk("down_no_extra_en", c_en, 3);
    c_cl = 0;
    press(2); step();
    chk("done_clear_pulse", c_cl, 1);
    chk("done_cleared", int'(done), 0);

    // Up count to 12 from a cleared counter
    mode_up = 1'b1; preset1 = 4'd1; preset0 = 4'd2;
    step(); step();
    c_en = 0; n = 0;
    press(0);
    while (!done && n < 200) begin step(); n++; end
    chk("up_enables", c_en, 12);
    chk("up_q_final", cval, 12);
    chk("up_done", int'(done), 1);
    press(2); step();
`else
    // Auto reload, down from 02
    mode_up = 1'b0; preset1 = 4'd0; preset0 = 4'd2;
    step(); step();
    press(1); step();
    c_en = 0; n = 0;
    press(0);
    while (!done && n < 60) begin step(); n++; end
    chk("auto_enables", c_en, 2);
    chk("auto_q_at_term", cval, 0);
    chk("auto_reload_load", int'(cnt_load), 1);
    chk("auto_running", int'(running), 1);
    chk("auto_alarm_on", int'(alarm), 1);
    all_run = 1'b1; k = 1;
    step();
    chk("auto_done_pulse", int'(done), 0);
    chk("auto_reloaded", cval, 2);
    if (alarm) k++;
    n = 0;
    while (alarm && n < 40) begin step(); n++; all_run &= running; if (alarm) k++; end
    chk("auto_alarm_len", k, AC * TD);
    chk("auto_stays_running", int'(all_run), 1);
    press(2); step();
`endif

    // Pause / resume
    mode_up = 1'b0; preset1 = 4'd0; preset0 = 4'd9;
    step();
    press(1); step();
    c_en = 0; n = 0;
    press(0);
    while (c_en < 2 && n < 40) begin step(); n++; end
    start_stop = 1'b1; step(); step(); start_stop = 1'b0;
    chk("pause_running", int'(running), 0);
    c_en = 0;
    repeat (20) step();
    chk("pause_no_en", c_en, 0);
    chk("pause_still", int'(running), 0);
    start_stop = 1'b1; step(); step(); start_stop = 1'b0;
    chk("resume_running", int'(running), 1);
    r = cyc; n = 0;
    while (n < 20) begin step(); n++; if (cnt_enable) break; end
    chk("resume_latency", cyc - r, TD);

    // Simultaneous clear + load + start in RUN
    c_cl = 0; c_ld = 0;
    start_stop = 1'b1; load_btn = 1'b1; clear_btn = 1'b1;
    step(); step();
    chk("simul_idle", int'({running, done}), 0);
    step(); step(); step();
    start_stop = 1'b0; load_btn = 1'b0; clear_btn = 1'b0;
    step();
    chk("simul_clear_once", c_cl, 1);
    chk("simul_no_load", c_ld, 0);
    chk("simul_q_zero", cval, 0);

    // Asynchronous reset mid-RUN
    preset0 = 4'd5;
    press(1); step();
    press(0);
    repeat (7) step();
    #3 reset = 1'b1;
    #1 chk("reset_async", int'(dut_v), 0);
    step();
    reset = 1'b0;
    step(); step();
    chk("idle_after_reset", int'({running, done, alarm, cnt_enable}), 0);
    press(0);
    chk("run_after_reset", int'(running), 1);

    // Random stimulus against the reference model
    reset = 1'b1;
    start_stop = 1'b0; load_btn = 1'b0; clear_btn = 1'b0;
    model_reset();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      model_edge();
      exp_v = {m_en, m_up, m_ld, m_cl, 4'(m_d1), 4'(m_d0), m_running,
               (AUTO ? m_dn : m_finished), (m_alarm_left > 0)};
      chk("random_outputs", int'(dut_v), int'(exp_v));
      start_stop = start_stop ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 119) == 0);
      load_btn   = load_btn   ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 149) == 0);
      clear_btn  = clear_btn  ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) begin
        preset1 = 4'($urandom_range(0, 15));
        preset0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) == 0) mode_up = ~mode_up;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
